// File: rtl/ysyx_25060173_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (m0) and LSU (m1).
// Ports: clk, reset (sync, active-low); m0_*/m1_* master req/resp; s_* slave.
// Optional macro ARB_TIMEOUT_EN: WAIT watchdog returning an error after
// TIMEOUT cycles without a slave response.
module ysyx_25060173_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_wen,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    output logic                m0_resp_valid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_resp_err,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_wen,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_resp_valid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_resp_err,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wen,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_resp_valid,
    input  logic [DATA_W-1:0]   s_rdata
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e              state_q;
    logic                last_q;
    logic                grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                win1_d;
    logic                take_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                wen_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [MASK_W-1:0]   wmask_d;
    logic                in_req;
    logic                resp0;
    logic                resp1;

    // On a tie the master that did not win last time gets the port.
    assign win1_d = (m0_req_valid && m1_req_valid) ? ~last_q : m1_req_valid;
    // Ready is masked during reset so nothing is accepted on a reset edge.
    assign take_d = reset && (state_q == IDLE) &&
                    (m0_req_valid || m1_req_valid);

    assign m0_req_ready = take_d && !win1_d;
    assign m1_req_ready = take_d && win1_d;

    assign addr_d  = win1_d ? m1_addr  : m0_addr;
    assign wen_d   = win1_d ? m1_wen   : m0_wen;
    assign wdata_d = win1_d ? m1_wdata : m0_wdata;
    assign wmask_d = win1_d ? m1_wmask : m0_wmask;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ?
                           $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (take_d) begin
                        grant_q <= win1_d;
                        last_q  <= win1_d;
                        addr_q  <= addr_d;
                        wen_q   <= wen_d;
                        wdata_q <= wdata_d;
                        wmask_q <= wmask_d;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (s_req_ready) begin
                        state_q <= WAIT;
`ifdef ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                WAIT: begin
                    // A real response wins over a coinciding timeout.
                    if (s_resp_valid) begin
                        rdata_q <= s_rdata;
                        state_q <= RESP;
`ifdef ARB_TIMEOUT_EN
                        err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
`endif
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_req  = (state_q == REQ);
    assign s_req_valid = in_req;
    assign s_addr  = in_req ? addr_q  : '0;
    assign s_wen   = in_req && wen_q;
    assign s_wdata = in_req ? wdata_q : '0;
    assign s_wmask = in_req ? wmask_q : '0;

    assign resp0 = (state_q == RESP) && !grant_q;
    assign resp1 = (state_q == RESP) && grant_q;

    assign m0_resp_valid = resp0;
    assign m1_resp_valid = resp1;
    assign m0_rdata = resp0 ? rdata_q : '0;
    assign m1_rdata = resp1 ? rdata_q : '0;

`ifdef ARB_TIMEOUT_EN
    assign m0_resp_err = resp0 && err_q;
    assign m1_resp_err = resp1 && err_q;
`else
    assign m0_resp_err = 1'b0;
    assign m1_resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25060173_mem_arbiter.sv
// Testbench for ysyx_25060173_mem_arbiter: directed scenarios plus random
// traffic, checked against a cycle-timestamp transaction model.
module tb_ysyx_25060173_mem_arbiter;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req_valid, m1_req_valid;
    logic        m0_req_ready, m1_req_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_wen, m1_wen;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_resp_valid, m1_resp_valid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_resp_err, m1_resp_err;
    logic        s_req_valid, s_req_ready, s_wen, s_resp_valid;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;

    always #5 clk = ~clk;

    ysyx_25060173_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_resp_valid(m0_resp_valid),
        .m0_rdata(m0_rdata), .m0_resp_err(m0_resp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_resp_valid(m1_resp_valid),
        .m1_rdata(m1_rdata), .m1_resp_err(m1_resp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata),
        .s_wmask(s_wmask), .s_resp_valid(s_resp_valid),
        .s_rdata(s_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // master pending requests
    logic        pv [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic        pw [2];
    logic [3:0]  pm [2];
    bit          refill [2];
    bit          rand_m;

    // slave behaviour knobs and state
    bit          sl_rand, sl_mute, sl_fix, sl_out;
    int          sl_hold, sl_dly, sl_wait, sl_age;
    logic [31:0] sl_data;

    // reference model: cycle stamps of accept, handshake, response
    int          cyc, acc, hs, rsp;
    bit          own, lastg;
    logic [31:0] ea, ed, erd;
    logic [3:0]  em;
    bit          ew, eer;
    bit          gq [$];

    // observations
    int          acc0, rsp0, rv_cnt, rv0_cnt, sreq_cnt;
    bit          err0, err1, obs_rdy0, obs_rdy1;
    logic [31:0] rd0;

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic w, input logic [31:0] d,
                           input logic [3:0] m);
        pv[i] = 1'b1; pa[i] = a; pw[i] = w; pd[i] = d; pm[i] = m;
    endtask

    task automatic drive_masters();
        for (int i = 0; i < 2; i++) begin
            if (!pv[i] && (refill[i] ||
                (rand_m && $urandom_range(2) == 0)))
                set_req(i, $urandom, 1'($urandom_range(1)),
                        $urandom, 4'($urandom));
        end
        m0_req_valid = pv[0]; m0_addr = pa[0]; m0_wen = pw[0];
        m0_wdata = pd[0]; m0_wmask = pm[0];
        m1_req_valid = pv[1]; m1_addr = pa[1]; m1_wen = pw[1];
        m1_wdata = pd[1]; m1_wmask = pm[1];
    endtask

    task automatic drive_slave();
        s_req_ready = 1'b0;
        s_resp_valid = 1'b0;
        s_rdata = sl_fix ? sl_data : $urandom;
        if (s_req_valid) begin
            s_req_ready = sl_rand ? 1'($urandom_range(1))
                                  : (sl_wait >= sl_hold);
            sl_wait++;
        end
        // never respond in a handshake cycle
        if (!s_req_ready) begin
            if (sl_out && !sl_mute) begin
                sl_age++;
                if (sl_rand ? ($urandom_range(2) == 0)
                            : (sl_age >= sl_dly)) begin
                    s_resp_valid = 1'b1;
                    sl_out = 1'b0;
                end
            end else if (sl_rand && !sl_out &&
                         $urandom_range(7) == 0) begin
                s_resp_valid = 1'b1;
            end
        end
    endtask

    task automatic step();
        bit er0, er1, esr, erv, win;
        logic [31:0] g_rd, o_rd;
        logic g_er, o_er;
        #1;
        er0 = 1'b0; er1 = 1'b0; win = 1'b0;
        if (reset && acc < 0) begin
            if (m0_req_valid && m1_req_valid)
                win = (lastg == 1'b1) ? 1'b0 : 1'b1;
            else
                win = m1_req_valid;
            er0 = m0_req_valid && !win;
            er1 = m1_req_valid && win;
        end
        esr = (acc >= 0) && (hs < 0);
        erv = (acc >= 0) && (rsp >= 0);
        check("m0_req_ready", m0_req_ready, er0);
        check("m1_req_ready", m1_req_ready, er1);
        check("s_req_valid", s_req_valid, esr);
        if (esr) begin
            check("s_addr", s_addr, ea);
            check("s_wen", s_wen, ew);
            check("s_wdata", s_wdata, ed);
            check("s_wmask", s_wmask, em);
        end
        check("m0_resp_valid", m0_resp_valid, erv && !own);
        check("m1_resp_valid", m1_resp_valid, erv && own);
        if (erv) begin
            g_rd = own ? m1_rdata : m0_rdata;
            o_rd = own ? m0_rdata : m1_rdata;
            g_er = own ? m1_resp_err : m0_resp_err;
            o_er = own ? m0_resp_err : m1_resp_err;
            check("resp_rdata", g_rd, erd);
            check("resp_err", g_er, eer);
            check("other_rdata", o_rd, 0);
            check("other_err", o_er, 0);
        end
        obs_rdy0 = m0_req_ready;
        obs_rdy1 = m1_req_ready;
        if (m0_req_ready) acc0 = cyc;
        if (m0_resp_valid) begin
            rsp0 = cyc; err0 = m0_resp_err; rd0 = m0_rdata; rv0_cnt++;
        end
        if (m1_resp_valid) err1 = m1_resp_err;
        if (m0_resp_valid || m1_resp_valid) rv_cnt++;
        if (s_req_valid) sreq_cnt++;
        if (!reset) begin
            acc = -1; hs = -1; rsp = -1; lastg = 1'b1;
        end else if (erv) begin
            acc = -1; hs = -1; rsp = -1;
        end else if (acc < 0) begin
            if (er0 || er1) begin
                own = win; lastg = win; acc = cyc;
                ea = win ? m1_addr : m0_addr;
                ew = win ? m1_wen : m0_wen;
                ed = win ? m1_wdata : m0_wdata;
                em = win ? m1_wmask : m0_wmask;
                gq.push_back(win);
            end
        end else if (hs < 0) begin
            if (s_req_ready) hs = cyc;
        end else if (s_resp_valid) begin
            rsp = cyc; erd = s_rdata; eer = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cyc - hs == TO) begin
            rsp = cyc; erd = '0; eer = 1'b1;
        end
`endif
        if (!reset) begin
            sl_out = 1'b0; sl_wait = 0;
        end else if (s_req_valid && s_req_ready) begin
            sl_out = 1'b1; sl_age = 0; sl_wait = 0;
        end
        if (m0_req_ready) pv[0] = 1'b0;
        if (m1_req_ready) pv[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic cycle();
        drive_masters();
        drive_slave();
        step();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while ((acc >= 0 || pv[0] || pv[1]) && k < budget) begin
            cycle();
            k++;
        end
        check("idle_budget", k < budget, 1);
    endtask

    initial begin
        int base, k, rv_b, rv0_b;
        reset = 1'b0;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; pw[i] = 1'b0;
            pm[i] = '0; refill[i] = 1'b0;
        end
        rand_m = 0; sl_rand = 0; sl_mute = 0; sl_fix = 0; sl_out = 0;
        sl_hold = 0; sl_dly = 1; sl_wait = 0; sl_age = 0; sl_data = '0;
        cyc = 0; acc = -1; hs = -1; rsp = -1; lastg = 1'b1; own = 1'b0;
        acc0 = 0; rsp0 = 0; rv_cnt = 0; rv0_cnt = 0; sreq_cnt = 0;
        err0 = 0; err1 = 0; rd0 = '0;

        // reset held two cycles with both masters requesting
        set_req(0, 32'h8000_0000, 1'b0, 32'h0, 4'hf);
        set_req(1, 32'h8000_0100, 1'b0, 32'h0, 4'hf);
        drive_masters();
        drive_slave();
        @(posedge clk);
        @(negedge clk);
        drive_masters();
        drive_slave();
        #1;
        check("rst_ready", {m0_req_ready, m1_req_ready}, 0);
        check("rst_s_req_valid", s_req_valid, 0);
        check("rst_s_fields", {s_addr, s_wdata}, 0);
        check("rst_s_ctl", {s_wen, s_wmask}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        check("rst_resp", {m0_resp_valid, m1_resp_valid,
                           m0_resp_err, m1_resp_err}, 0);
        step();
        reset = 1'b1;
        cycle();
        check("first_grant", {obs_rdy0, obs_rdy1}, 2'b10);
        run_until_idle(40);

        // single read with minimum latency
        sl_fix = 1; sl_data = 32'h0010_0073;
        set_req(0, 32'h8000_0000, 1'b0, 32'h0, 4'hf);
        run_until_idle(20);
        check("rd_latency", rsp0 - acc0, 3);
        check("rd_data", rd0, 32'h0010_0073);
        sl_fix = 0;

        // write with slave stalling 5 cycles
        sl_hold = 5; sreq_cnt = 0; err1 = 1'b1;
        set_req(1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hf);
        run_until_idle(30);
        check("wr_req_cycles", sreq_cnt, 6);
        check("wr_err", err1, 0);
        sl_hold = 0;

        // contention: grants must alternate starting with m0
        base = gq.size();
        refill[0] = 1; refill[1] = 1;
        k = 0;
        while (gq.size() < base + 4 && k < 100) begin
            cycle();
            k++;
        end
        check("cont_budget", k < 100, 1);
        refill[0] = 0; refill[1] = 0;
        run_until_idle(50);
        for (int i = 0; i < 4; i++)
            check("cont_grant", gq[base + i], i % 2);

        // reset while waiting for the slave
        sl_mute = 1;
        set_req(0, 32'h8000_0040, 1'b0, 32'h0, 4'hf);
        k = 0;
        while (!(hs >= 0 && rsp < 0) && k < 20) begin
            cycle();
            k++;
        end
        check("mid_reach_wait", k < 20, 1);
        cycle();
        rv_b = rv_cnt;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        drive_masters();
        drive_slave();
        s_resp_valid = 1'b1;
        s_rdata = 32'h1234_5678;
        step();
        run_cycles(3);
        check("mid_no_resp", rv_cnt - rv_b, 0);
        sl_mute = 0;
        rv0_b = rv0_cnt;
        set_req(0, 32'h8000_0044, 1'b0, 32'h0, 4'hf);
        run_until_idle(20);
        check("mid_next_m0", rv0_cnt - rv0_b, 1);

`ifdef ARB_TIMEOUT_EN
        // slave never answers: error response after TO wait cycles
        sl_mute = 1;
        set_req(0, 32'h8000_0080, 1'b0, 32'h0, 4'hf);
        run_until_idle(40);
        check("to_err", err0, 1);
        check("to_rdata", rd0, 0);
        check("to_latency", rsp0 - acc0, TO + 2);
        sl_mute = 0;
        sl_out = 0;
`else
        // slave never answers: arbiter waits indefinitely
        sl_mute = 1;
        rv_b = rv_cnt;
        set_req(0, 32'h8000_0080, 1'b0, 32'h0, 4'hf);
        run_cycles(120);
        check("hang_no_resp", rv_cnt - rv_b, 0);
        check("hang_no_req", s_req_valid, 0);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        sl_mute = 0;
        sl_out = 0;
`endif

        // random traffic
        rand_m = 1;
        sl_rand = 1;
        run_cycles(3000);
        rand_m = 0;
        run_until_idle(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25060173_mem_arbiter.md
# ysyx_25060173_mem_arbiter

Two-master, one-slave memory arbiter that lets the instruction fetch unit (master 0) and the load/store unit (master 1) share the single physical memory port used by the multi-cycle core. It accepts at most one transaction at a time, selects a winner by round-robin, forwards the request to the memory slave, and returns read data to the granted master as a one-cycle response pulse. It sits between the IFU/LSU and the memory access block that wraps the `pmem_read`/`pmem_write` DPI calls.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; the write mask is `DATA_W/8` bits.
- `TIMEOUT`, default 255: watchdog limit in cycles. Used only with `ARB_TIMEOUT_EN`.

- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `m0_req_valid` / `m1_req_valid` in 1: the master has a request pending.
- `m0_req_ready` / `m1_req_ready` out 1: request accepted this cycle.
- `m0_addr` / `m1_addr` in ADDR_W: request address.
- `m0_wen` / `m1_wen` in 1: 1 = write, 0 = read.
- `m0_wdata` / `m1_wdata` in DATA_W: write data.
- `m0_wmask` / `m1_wmask` in DATA_W/8: byte enables.
- `m0_resp_valid` / `m1_resp_valid` out 1: one-cycle response pulse.
- `m0_rdata` / `m1_rdata` out DATA_W: read data, valid only while `resp_valid` is high.
- `m0_resp_err` / `m1_resp_err` out 1: response is an error.
- `s_req_valid` out 1: request to the slave.
- `s_req_ready` in 1: the slave accepts the request.
- `s_addr` out ADDR_W, `s_wen` out 1, `s_wdata` out DATA_W, `s_wmask` out DATA_W/8: request fields sent to the slave.
- `s_resp_valid` in 1: the slave's response.
- `s_rdata` in DATA_W: the slave's read data.

## Operation
**Reset values.** With `reset`=0 at a clock edge:
- state becomes IDLE and `last_grant` becomes 1;
- all `*_ready`, `*_resp_valid`, `*_resp_err` and `s_req_valid` are 0;
- all data and address outputs are 0;
- the timeout counter is 0.

**State machine:** IDLE, REQ, WAIT, RESP.
- **IDLE**
  - Winner selection:
    - only m0 valid: grant 0;
    - only m1 valid: grant 1;
    - both valid: grant the master that is not `last_grant`.
  - The winner's `req_ready` is driven high combinationally in the same cycle. The loser's `req_ready` stays 0.
  - On the edge: latch addr, wen, wdata, wmask and grant; set `last_grant` to the grant; go to REQ.
  - With no request, stay in IDLE.
- **REQ**
  - `s_req_valid`=1 and the `s_*` fields come from the latched registers; they are held stable until accepted.
  - On `s_req_valid && s_req_ready`: go to WAIT and clear the timeout counter.
- **WAIT**
  - On `s_resp_valid`: capture `s_rdata` into the response register (capture for writes too), set err=0, go to RESP.
- **RESP**
  - The granted master's `resp_valid`=1 for exactly one cycle, with `rdata`/`resp_err` driven from the response registers.
  - The other master's outputs are 0.
  - Go to IDLE.

**Slave contract.**
- The slave must not assert `s_resp_valid` in the cycle of the request handshake.
- `s_resp_valid` is ignored in IDLE, REQ and RESP.

**Masters.**
- Masters always accept responses; there is no response back-pressure.
- A master keeps `req_valid` high until it sees `req_ready`.
- Requests are never reordered: one transaction is outstanding at a time.

**Reset mid-operation.**
- The in-flight transaction is dropped and no response is issued.
- A slave response arriving after reset is ignored because the block is in IDLE.

## Timing
- **Minimum latency.**
  - Accept in cycle T;
  - `s_req_valid` in T+1;
  - slave ready in T+1 and response in T+2 (WAIT);
  - master `resp_valid` in T+3.
  - Total: 3 cycles from accept to response.
- **Throughput.** The next accept comes no earlier than the cycle after RESP, i.e. T+4. Maximum is one transaction per 4 cycles.
- **Output sources.** `req_ready` is combinational from `req_valid` and state. All other outputs are registered or decoded from state.

## Configuration
- **`ARB_TIMEOUT_EN` defined:**
  - In WAIT, an 8+-bit counter (wide enough for `TIMEOUT`) increments every cycle.
  - If it reaches `TIMEOUT` with no `s_resp_valid`, go to RESP with `resp_err`=1 and `rdata`=0.
  - If `s_resp_valid` and the limit coincide in the same cycle, the real response wins and err=0.
- **`ARB_TIMEOUT_EN` not defined:**
  - No counter is built and `resp_err` is constant 0.
  - WAIT holds indefinitely until `s_resp_valid`.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with both masters requesting. Required: all outputs 0 and no `s_req_valid`. Release reset: m0 is granted first (`last_grant`=1).
- **Single read:** m0 reads 0x80000000; slave ready immediately, responds the next cycle with 0x00100073. Required: `m0_resp_valid` pulses once 3 cycles after accept with `m0_rdata`=0x00100073; m1 outputs stay 0.
- **Contention:** both masters request continuously for 4 transactions. Required: grants alternate 0,1,0,1 and every response routes to the correct master.
- **Write:** m1 writes 0xDEADBEEF with mask 0xF to 0x80001000, while the slave holds `s_req_ready`=0 for 5 cycles. Required: `s_addr`/`s_wdata`/`s_wmask` stay stable for all 5 cycles; `m1_resp_valid`=1 with err=0.
- **Reset mid-operation:** assert reset while in WAIT, then have the slave respond 1 cycle after release. Required: no `resp_valid` is issued and the next m0 request is served normally.
- **Timeout (with `ARB_TIMEOUT_EN`, `TIMEOUT`=10):** the slave never responds. Required: RESP occurs after 10 WAIT cycles with `m0_resp_err`=1 and `m0_rdata`=0. Without the macro: the block stays in WAIT for 100+ cycles.
